// File: rtl/fust_scalar_sched.sv
// fust_scalar_sched: scoreboard scheduler for the scalar function units
// (ALU=0, LD_ST=1, BRANCH=2). One status row per FU plus a register
// result-status table; rows are accepted from dispatch when free of
// structural/WAW/WAR hazards, wait for RAW producers, are issued
// round-robin and retired by FU writeback.
module fust_scalar_sched #(
   parameter int NUM_FU = 3,
   parameter int FU_W   = 2,
   parameter int REG_W  = 5,
   parameter int NREGS  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              disp_valid,
   output logic              disp_ready,
   input  logic [FU_W-1:0]   disp_fu,
   input  logic              disp_rd_en,
   input  logic [REG_W-1:0]  disp_rd,
   input  logic [REG_W-1:0]  disp_rs1,
   input  logic [REG_W-1:0]  disp_rs2,
   output logic              issue_valid,
   output logic [FU_W-1:0]   issue_fu,
   output logic [REG_W-1:0]  issue_rd,
   output logic [REG_W-1:0]  issue_rs1,
   output logic [REG_W-1:0]  issue_rs2,
   input  logic [NUM_FU-1:0] issue_ready,
   input  logic              wb_valid,
   input  logic [FU_W-1:0]   wb_fu,
   output logic [NUM_FU-1:0] fu_busy
);

   // All-ones tag means "no pending producer".
   localparam logic [FU_W-1:0] NONE = '1;

   typedef struct packed {
      logic             busy;
      logic             issued;
      logic [REG_W-1:0] r;
      logic [REG_W-1:0] r1;
      logic [REG_W-1:0] r2;
      logic [FU_W-1:0]  t1;
      logic [FU_W-1:0]  t2;
   } row_t;

   localparam row_t ROW_IDLE = '{busy: 1'b0, issued: 1'b0, r: '0, r1: '0, r2: '0,
                                 t1: NONE, t2: NONE};

   row_t             rows [NUM_FU];
   logic [FU_W-1:0]  rstat [NREGS];
   logic [FU_W-1:0]  ptr;

   logic             fu_ok;
   logic             slot_free;
   logic             wb_same;
   logic             waw_ok;
   logic             war_ok;
   logic             disp_fire;
   logic             wb_hit;
   logic [REG_W-1:0] wb_r;
   logic [FU_W-1:0]  new_t1;
   logic [FU_W-1:0]  new_t2;
   row_t             new_row;
   logic [FU_W-1:0]  issue_sel;
   logic [FU_W-1:0]  ptr_next;
   int               scan_idx;

   // Dispatch acceptance: FU range, structural, WAW and WAR hazards on pre-writeback state.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      slot_free = 1'b0;
      war_ok    = 1'b1;
      fu_ok     = (disp_fu < FU_W'(NUM_FU));
      wb_same   = wb_valid && (wb_fu == disp_fu);
      waw_ok    = !(disp_rd_en && (disp_rd != '0) && (rstat[disp_rd] != NONE));
      for (int i = 0; i < NUM_FU; i++) begin
         if (disp_fu == FU_W'(i)) slot_free = !rows[i].busy;
         if (disp_rd_en && rows[i].busy && !rows[i].issued &&
             (((rows[i].r1 == disp_rd) && (rows[i].r1 != '0)) ||
              ((rows[i].r2 == disp_rd) && (rows[i].r2 != '0))))
            war_ok = 1'b0;
      end
      disp_ready = fu_ok && slot_free && !wb_same && waw_ok && war_ok;
      disp_fire  = disp_valid && disp_ready;
   end

   // Writeback qualification: only a busy, issued row can retire.
   always_comb begin
      wb_hit = 1'b0;
      wb_r   = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (wb_valid && (wb_fu == FU_W'(i)) && rows[i].busy && rows[i].issued) begin
            wb_hit = 1'b1;
            wb_r   = rows[i].r;
         end
      end
   end

   // New row contents, with producer tags bypassed against a same-cycle retirement.
   always_comb begin
      new_t1 = (disp_rs1 == '0) ? NONE : rstat[disp_rs1];
      new_t2 = (disp_rs2 == '0) ? NONE : rstat[disp_rs2];
      if (wb_hit && (new_t1 == wb_fu)) new_t1 = NONE;
      if (wb_hit && (new_t2 == wb_fu)) new_t2 = NONE;
      new_row = '{busy: 1'b1, issued: 1'b0,
                  r: disp_rd_en ? disp_rd : '0,
                  r1: disp_rs1, r2: disp_rs2,
                  t1: new_t1, t2: new_t2};
   end

   // Round-robin issue select starting at ptr.
   always_comb begin
      issue_valid = 1'b0;
      issue_sel   = '0;
      issue_rd    = '0;
      issue_rs1   = '0;
      issue_rs2   = '0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan_idx = int'(ptr) + k;
         if (scan_idx >= NUM_FU) scan_idx = scan_idx - NUM_FU;
         for (int i = 0; i < NUM_FU; i++) begin
            if ((i == scan_idx) && !issue_valid && rows[i].busy && !rows[i].issued &&
                (rows[i].t1 == NONE) && (rows[i].t2 == NONE) && issue_ready[i]) begin
               issue_valid = 1'b1;
               issue_sel   = FU_W'(i);
               issue_rd    = rows[i].r;
               issue_rs1   = rows[i].r1;
               issue_rs2   = rows[i].r2;
            end
         end
      end
      issue_fu = issue_sel;
      ptr_next = (issue_sel == FU_W'(NUM_FU - 1)) ? '0 : issue_sel + 1'b1;
   end

   // Busy vector straight from the row registers.
   always_comb begin
      fu_busy = '0;
      for (int i = 0; i < NUM_FU; i++) fu_busy[i] = rows[i].busy;
   end

   // Row, result-status and pointer updates for writeback, issue and dispatch.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         // NOTE: rstat is a table but is reset like plain flops; a stale producer tag would stall dispatch forever.
         for (int i = 0; i < NUM_FU; i++) rows[i] <= ROW_IDLE;
         for (int i = 0; i < NREGS; i++) rstat[i] <= NONE;
         ptr <= '0;
      end else begin
         // NOTE: non-blocking only; where two updates hit the same field, the later statement wins, so dispatch is written last.
         if (wb_hit) begin
            for (int i = 0; i < NUM_FU; i++) begin
               if (rows[i].t1 == wb_fu) rows[i].t1 <= NONE;
               if (rows[i].t2 == wb_fu) rows[i].t2 <= NONE;
               if (wb_fu == FU_W'(i)) begin
                  rows[i].busy   <= 1'b0;
                  rows[i].issued <= 1'b0;
               end
            end
            if ((wb_r != '0) && (rstat[wb_r] == wb_fu)) rstat[wb_r] <= NONE;
         end
         if (issue_valid) begin
            for (int i = 0; i < NUM_FU; i++)
               if (issue_sel == FU_W'(i)) rows[i].issued <= 1'b1;
            ptr <= ptr_next;
         end
         if (disp_fire) begin
            for (int i = 0; i < NUM_FU; i++)
               if (disp_fu == FU_W'(i)) rows[i] <= new_row;
            if (disp_rd_en && (disp_rd != '0)) rstat[disp_rd] <= disp_fu;
         end
      end
   end

endmodule

// File: doc/fust_scalar_sched.md
Name: fust_scalar_sched

Overview:
Scoreboard scheduler for the three scalar function units: ALU=0, LD_ST=1, BRANCH=2.
- Holds one FU-status row per scalar FU: busy, r, r1, r2, t1, t2, plus an issued flag.
- Holds a 32-entry register result-status table.
- Accepts instructions from dispatch, blocks on structural/WAW/WAR hazards, tracks RAW producers, and round-robin issues operand-ready rows to their FUs.
- Sits between the dispatch stage and the scalar FU datapaths; writeback events from the FUs retire rows.

Parameters:
NUM_FU, 3, number of scalar FU rows (tags 0..NUM_FU-1)
FU_W, 2, FU tag width; tag 3 = NONE (no pending producer)
REG_W, 5, register index width
NREGS, 32, architectural scalar registers; x0 never tracked

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
disp_valid  in  1  dispatch offers instruction
disp_ready  out  1  scheduler accepts (combinational)
disp_fu  in  FU_W  target FU tag
disp_rd_en  in  1  instruction writes rd
disp_rd  in  REG_W  destination register
disp_rs1  in  REG_W  source 1 (0 = unused)
disp_rs2  in  REG_W  source 2 (0 = unused)
issue_valid  out  1  a row is issued this cycle
issue_fu  out  FU_W  issued FU tag
issue_rd  out  REG_W  issued row r
issue_rs1  out  REG_W  issued row r1
issue_rs2  out  REG_W  issued row r2
issue_ready  in  NUM_FU  per-FU ready to accept
wb_valid  in  1  FU completion
wb_fu  in  FU_W  completing FU tag
fu_busy  out  NUM_FU  row busy vector

Behaviour:
Reset (async, nRST low):
- All rows busy=0, issued=0, t1=t2=NONE.
- rstat[*]=NONE; round-robin pointer ptr=0.
- issue_valid=0; fu_busy=0.
- Reset mid-operation discards all rows and status; in-flight FU results arriving after reset are ignored, because no row is busy.

Dispatch accept (fire = disp_valid & disp_ready). disp_ready=1 iff all of the following hold, evaluated on pre-writeback state:
- disp_fu < NUM_FU.
- Structural: row[disp_fu].busy=0; no bypass from a same-cycle wb of that FU.
- WAW: !(disp_rd_en & disp_rd!=0 & rstat[disp_rd]!=NONE).
- WAR: no row with busy=1 & issued=0 has (r1==disp_rd & r1!=0) or (r2==disp_rd & r2!=0), when disp_rd_en.

On fire, at the clock edge:
- Row[disp_fu] gets busy=1, issued=0, r = disp_rd_en ? disp_rd : 0, r1=rs1, r2=rs2.
- t1 = (rs1==0) ? NONE : rstat[rs1]; t2 likewise.
- Tag bypass: if wb_valid and the looked-up tag equals wb_fu, store NONE.
- rstat[disp_rd] <= disp_fu if disp_rd_en & disp_rd!=0.

Issue:
- A row is eligible iff busy & !issued & t1==NONE & t2==NONE & issue_ready[fu].
- Selection is round-robin starting at ptr, scanning ptr, ptr+1, ... mod NUM_FU.
- issue_valid and issue_* are combinational from registered state and issue_ready.
- On issue: row issued<=1; ptr <= (selected+1) mod NUM_FU.
- At most one issue per cycle.
- Minimum dispatch-to-issue latency is 1 cycle: accepted at edge N, issue_valid during cycle N+1.

Writeback (wb_valid, with row[wb_fu] busy & issued):
- Row busy<=0, issued<=0.
- If r!=0 and rstat[r]==wb_fu, then rstat[r]<=NONE.
- Every row with t1==wb_fu or t2==wb_fu has that tag set to NONE; such rows become eligible the next cycle.
- wb to an idle or non-issued row is ignored with no state change.
- wb_fu==3 is ignored.

Simultaneous events:
- wb and dispatch: wb updates and dispatch updates apply at the same edge; dispatch tag lookup uses the bypass above.
- Dispatch to the FU being written back is stalled for that cycle.
- Issue and wb: issue may select a row in the same cycle a different row retires.

fu_busy = registered row busy bits.

Test Plan:
1. Reset, issue_ready=111. Dispatch ALU rd=3 rs1=1 rs2=2 -> disp_ready=1, fu_busy=001. Next cycle issue_valid=1, issue_fu=0, rd=3, rs1=1, rs2=2. wb_fu=0 -> fu_busy=000, rstat[3]=NONE.
2. RAW: ALU writes x5 (issued, pending), then LD_ST rs1=5 -> row1 t1=0, no issue. wb ALU -> LD_ST issues exactly 1 cycle later.
3. Structural/WAW: ALU busy, second ALU dispatch -> disp_ready=0 until the cycle after wb. LD_ST rd=7 while ALU owns x7 -> stalled until ALU wb.
4. WAR: LD_ST waiting (t1 pending) with rs2=4; ALU dispatch rd=4 -> disp_ready=0. After LD_ST issues -> accepted.
5. Round-robin: all three rows eligible, ptr=0 -> issue order ALU, LD_ST, BRANCH on consecutive cycles. Repeat with ptr=1 -> LD_ST, BRANCH, ALU. With issue_ready=010 -> only LD_ST issues.
6. Same-cycle wb of ALU(x9) and dispatch BRANCH rs1=9 -> stored t1=NONE, BRANCH issues next cycle. nRST pulse mid-stream -> all outputs and fu_busy=0 immediately; a later wb_valid is ignored.
